// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame transmitter and its future receiver checker.
package serial_frame_pkg;

   localparam int   DEF_WIDTH     = 4;
   localparam logic DEF_START_LVL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Words narrower than 16 bits are zero-extended, which leaves the parity unchanged.
   function automatic logic even_parity(input logic [15:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel word handshake into the serial frame transmitter.
interface serial_frame_tx_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_shift_out.sv
// Load/shift-left data register with MSB tap and a down-counter of the data bits still to send.
module serial_shift_out #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             cnt_dec,
   input  logic [WIDTH-1:0] din,
   output logic             msb,
   output logic             cnt_zero
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh  <= '0;
         cnt <= '0;
      end else if (load) begin
         sh  <= din;
         cnt <= CW'(WIDTH - 1);
      end else begin
         if (shift)
            sh <= {sh[WIDTH-2:0], 1'b0};
         if (cnt_dec && cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   assign msb      = sh[WIDTH-1];
   assign cnt_zero = (cnt == '0);
endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: start bit, data MSB-first, optional parity, stop bit.
// Parity bit is present only when SERIAL_FRAME_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line at ~START_LVL, accepting a word
// START  | start bit on the line
// DATA   | data bits on the line, MSB first
// PARITY | even parity of the captured word on the line
// STOP   | stop bit on the line, done high
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int   WIDTH     = DEF_WIDTH,
   parameter logic START_LVL = DEF_START_LVL
) (
   input  logic               clk,
   input  logic               rst,
   serial_frame_tx_if.slave   bus,
   output logic               a,
   output logic               busy,
   output logic               done
);
   tx_state_t state;
   logic      transfer;
   logic      msb;
   logic      cnt_zero;
   logic      shift;
   logic      cnt_dec;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic      par;
`endif

   assign bus.din_ready = (state == IDLE);
   assign transfer      = bus.din_valid && (state == IDLE);
   assign cnt_dec       = (state == DATA) && !cnt_zero;
   assign shift         = (state == START) || cnt_dec;

   serial_shift_out #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .rst      (rst),
      .load     (transfer),
      .shift    (shift),
      .cnt_dec  (cnt_dec),
      .din      (bus.din),
      .msb      (msb),
      .cnt_zero (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a     <= ~START_LVL;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (bus.din_valid) begin
                  state <= START;
                  a     <= START_LVL;
                  busy  <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  par   <= even_parity(16'(bus.din));
`endif
               end else begin
                  a <= ~START_LVL;
               end
            end
            START: begin
               state <= DATA;
               a     <= msb;
            end
            DATA: begin
               // cnt_zero means the last data bit is on the line now
               if (cnt_zero) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  state <= PARITY;
                  a     <= par;
`else
                  state <= STOP;
                  a     <= ~START_LVL;
                  done  <= 1'b1;
`endif
               end else begin
                  a <= msb;
               end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
               state <= STOP;
               a     <= ~START_LVL;
               done  <= 1'b1;
            end
`endif
            STOP: begin
               state <= IDLE;
               a     <= ~START_LVL;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               a     <= ~START_LVL;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial transmitter that drives the single-bit serial line consumed by the 4-bit serial-to-parallel receiver (test2).
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits one framed bit per clk cycle: start bit, data MSB-first, optional parity, stop bit.
- Sits upstream of the receiver; its output `a` connects directly to the receiver's `a` input on the same clk.

Parameters:
- WIDTH, 4, data bits per frame (legal range 2..16).
- START_LVL, 1, line level of the start bit; idle and stop level is ~START_LVL.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- a  output  1  serial line, registered.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse, high while the stop bit is on the line.

Behaviour:
- Reset (rst high at posedge) forces:
  - state=IDLE, a=~START_LVL, din_ready=1, busy=0, done=0.
  - Shift register and bit counter cleared.
  - Reset mid-frame aborts the frame immediately; the partial word is discarded and nothing is replayed.
- Handshake:
  - Transfer occurs on a posedge where din_valid && din_ready.
  - din is captured into the shift register on that edge.
  - din_ready = (state==IDLE), combinational from registered state.
  - din_valid while busy is ignored; no capture, no effect on the frame.
  - din may change freely after capture.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
  - IDLE -> START on transfer. a=START_LVL in the cycle after the transfer edge.
  - START -> DATA after 1 cycle. a=din[WIDTH-1] first, then one bit per cycle down to din[0] (shift left, MSB out).
  - The bit counter counts 0..WIDTH-1; on the last data bit go to PARITY if enabled, else STOP.
  - STOP: a=~START_LVL for 1 cycle, done=1. Then go to IDLE.
  - IDLE holds a=~START_LVL.
- Latency and throughput:
  - First bit (start) appears 1 cycle after the transfer edge.
  - Frame length is WIDTH+2 cycles (WIDTH+3 with parity).
  - IDLE lasts a minimum of 1 cycle between frames, so back-to-back period is WIDTH+3 cycles (WIDTH+4 with parity).
- A data word of all START_LVL-inverse bits (e.g. 0000 with START_LVL=1) is still framed correctly; the receiver distinguishes it by the start bit.
- The counter is sized $clog2(WIDTH)+1 and never wraps within a frame.
- Simultaneous rst and din_valid: rst wins, and no capture occurs.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - a = even parity (XOR of all captured data bits) for 1 cycle.
  - Frame is WIDTH+3 cycles.
- Undefined:
  - No PARITY state and no parity logic.
  - DATA -> STOP directly.

Decomposition:
- Package serial_frame_pkg holds:
  - State enum tx_state_t (IDLE, START, DATA, PARITY, STOP).
  - Localparam for the default WIDTH=4 and default START_LVL=1.
  - Function even_parity() shared with the future receiver checker.
- One sub-module: serial_shift_out.
  - WIDTH-bit load/shift-left register with msb output and a down-counter.
  - Owned by the FSM in serial_frame_tx.

Test Plan:
- Reset, then idle 5 cycles -> a=0, din_ready=1, busy=0, done=0 throughout.
- din=4'b1011 with a 1-cycle valid pulse -> a over the next 6 cycles = 1,1,0,1,1,0; done high only on cycle 6; din_ready low for cycles 1-6.
- din=4'b0000 -> a = 1,0,0,0,0,0; receiver test2 reports r=0000.
- din_valid held high with din=4'b1100 then 4'b0011 -> frames 1,1,1,0,0,0 then 1,0,0,1,1,0; exactly one IDLE cycle between frames; the word changed during busy is not captured.
- rst asserted during the second data bit of 4'b1011 -> next cycle a=0, busy=0, din_ready=1, no done pulse; a following 4'b0110 frame is clean (1,0,1,1,0,0).
- With SERIAL_FRAME_TX_PARITY_EN, din=4'b1011 -> a = 1,1,0,1,1,1,0 (parity=1); din=4'b1001 -> parity bit 0.
